// File: rtl/dot_accel_pkg.sv
// dot_accel_pkg: shared FSM states, width and lane-slice helpers for the dot-product accelerator
package dot_accel_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;
`ifdef DOT_ACCEL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  function automatic int lane_lo(input int lane, input int data_w);
    return lane * data_w;
  endfunction
  function automatic int sum_w(input int acc_w, input int lanes);
    return acc_w + (SAT_EN ? $clog2(lanes) + 1 : 0);
  endfunction
endpackage

// File: rtl/dot_product_stream_accel_dot_lane_tree.sv
// dot_lane_tree: masked lane multipliers (S1) feeding a registered adder tree (S2)
module dot_lane_tree
  import dot_accel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES = 4,
  parameter int ACC_W = 64,
  localparam int SW = sum_w(ACC_W, LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [LANES-1:0]          mask,
  input  logic [LANES*DATA_W-1:0]   a,
  input  logic [LANES*DATA_W-1:0]   b,
  output logic signed [SW-1:0]      sum,
  output logic                      sum_valid,
  output logic                      pending
);
  logic signed [2*DATA_W-1:0] mul [LANES];
  logic signed [2*DATA_W-1:0] prod_q [LANES];
  logic signed [2*DATA_W-1:0] prod_d [LANES];
  logic signed [SW-1:0] sum_q, sum_d, tree;
  logic v1_q, v1_d, v2_q, v2_d;
  always_comb begin
    v1_d = valid;
    v2_d = v1_q;
    tree = '0;
    prod_d = prod_q;
    mul = prod_q;
    for (int i = 0; i < LANES; i++) begin
      mul[i] = $signed(a[lane_lo(i, DATA_W) +: DATA_W]) * $signed(b[lane_lo(i, DATA_W) +: DATA_W]);
      prod_d[i] = valid ? (mask[i] ? mul[i] : '0) : prod_q[i];
      tree = tree + SW'(prod_q[i]);
    end
    sum_d = v1_q ? tree : sum_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '{default: '0};
      sum_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      sum_q <= sum_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end
  assign sum = sum_q;
  assign sum_valid = v2_q;
  assign pending = v1_q | v2_q;
endmodule

// File: rtl/dot_product_stream_accel.sv
// dot_product_stream_accel: streamed signed dot product with accumulate chaining; define DOT_ACCEL_SAT_EN for saturating accumulate and sat_ovf
module dot_product_stream_accel
  import dot_accel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES = 4,
  parameter int MAX_LEN = 256,
  parameter int ACC_W = 64,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    cmd_accum,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_data,
  output logic                    busy
`ifdef DOT_ACCEL_SAT_EN
  ,
  output logic                    sat_ovf
`endif
);
  localparam int SW = sum_w(ACC_W, LANES);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, beats_q, beats_d, len_c, rem;
  logic signed [ACC_W-1:0] acc_q, acc_d, prev_q, prev_d, res_q, res_d, acc_add;
  logic signed [SW-1:0] sum;
  logic [LANES-1:0] mask;
  logic sum_valid, pending, fire;
  assign cmd_ready = state_q == IDLE && !rst;
  assign in_ready = state_q == STREAM && beats_q != '0 && !rst;
  assign res_valid = state_q == DONE && !rst;
  assign busy = state_q != IDLE && !rst;
  assign res_data = res_q;
  assign fire = in_valid && in_ready;
  assign len_c = cmd_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len;
  assign rem = len_q % LEN_W'(LANES);
  always_comb begin
    mask = '1;
    for (int i = 0; i < LANES; i++) mask[i] = !(beats_q == LEN_W'(1) && rem != '0 && LEN_W'(i) >= rem);
  end
  dot_lane_tree #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W)) u_tree (
    .clk(clk), .rst(rst), .valid(fire), .mask(mask), .a(in_a), .b(in_b),
    .sum(sum), .sum_valid(sum_valid), .pending(pending)
  );
`ifdef DOT_ACCEL_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [SW-1:0] wide;
  logic ovf_q, ovf_d, ovf_add;
  always_comb begin
    wide = SW'(acc_q) + sum;
    ovf_add = wide > SW'(ACC_MAX) || wide < SW'(ACC_MIN);
    acc_add = wide > SW'(ACC_MAX) ? ACC_MAX : wide < SW'(ACC_MIN) ? ACC_MIN : wide[ACC_W-1:0];
  end
  assign sat_ovf = ovf_q;
`else
  assign acc_add = acc_q + sum;
`endif
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    beats_d = beats_q;
    prev_d = prev_q;
    res_d = res_q;
    acc_d = sum_valid ? acc_add : acc_q;
`ifdef DOT_ACCEL_SAT_EN
    ovf_d = ovf_q | (sum_valid & ovf_add);
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        len_d = len_c;
        beats_d = LEN_W'(({1'b0, len_c} + (LEN_W+1)'(LANES - 1)) / (LEN_W+1)'(LANES));
        acc_d = cmd_accum ? prev_q : '0;
        res_d = len_c == '0 ? (cmd_accum ? prev_q : '0) : res_q;
`ifdef DOT_ACCEL_SAT_EN
        ovf_d = cmd_accum & ovf_q;
`endif
        state_d = len_c == '0 ? DONE : STREAM;
      end
      STREAM: if (fire) begin
        beats_d = beats_q - LEN_W'(1);
        state_d = beats_q == LEN_W'(1) ? DRAIN : STREAM;
      end
      DRAIN: if (!pending) begin
        res_d = acc_q;
        prev_d = acc_q;
        state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      beats_q <= '0;
      acc_q <= '0;
      prev_q <= '0;
      res_q <= '0;
`ifdef DOT_ACCEL_SAT_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      beats_q <= beats_d;
      acc_q <= acc_d;
      prev_q <= prev_d;
      res_q <= res_d;
`ifdef DOT_ACCEL_SAT_EN
      ovf_q <= ovf_d;
`endif
    end
  end
endmodule
